// File: rtl/soc_pll_cfg_ctrl.sv
// PLL configuration controller: accepts a config word over valid/ready, parks the SoC
// clock on bypass, programs the PLL, waits for a stable lock, then releases bypass.
module soc_pll_cfg_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned LOCK_STABLE   = 32,
    parameter int unsigned LOCK_TIMEOUT  = 4096,
    parameter int unsigned CNT_W         = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cfg_i,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    output logic [7:0]  pll_mult_o,
    output logic [3:0]  pll_rdiv_o,
    output logic [3:0]  pll_odiv_o,
    output logic [1:0]  pll_ctrl_o,
    output logic        pll_update_o,
    output logic        pll_bypass_o,
    input  logic        pll_lock_i,
    output logic [1:0]  status_o,
    output logic        err_o
);

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_BAD     = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_BUSY    = 2'b11;

    typedef struct packed {
        logic       fb_en;
        logic       bw;
        logic [3:0] odiv;
        logic [3:0] rdiv;
        logic [7:0] mult;
    } pll_cfg_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REJECT,
        S_BYPASS,
        S_PROGRAM,
        S_LOCK_WAIT,
        S_RELEASE,
        S_FAIL
    } state_t;

    state_t           state_q, state_d;
    pll_cfg_t         cfg_q, cfg_d;
    pll_cfg_t         cfg_in;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] stable_q, stable_d;
    logic             lock_meta_q, lock_sync_q;
    logic             ready_d, update_d, bypass_d, err_d;
    logic [7:0]       mult_d;
    logic [3:0]       rdiv_d, odiv_d;
    logic [1:0]       ctrl_d, status_d;
    logic             cfg_bad;
    logic             unused_rsvd;

    assign cfg_in      = pll_cfg_t'(cfg_i[17:0]);
    assign cfg_bad     = (cfg_in.mult == 8'd0) || (cfg_in.rdiv == 4'd0) || (cfg_in.odiv == 4'd0);
    assign unused_rsvd = ^cfg_i[31:18];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // State, counters, lock synchroniser and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cfg_q        <= '0;
            cnt_q        <= '0;
            stable_q     <= '0;
            lock_meta_q  <= 1'b0;
            lock_sync_q  <= 1'b0;
            cfg_ready_o  <= 1'b1;
            pll_mult_o   <= 8'd1;
            pll_rdiv_o   <= 4'd1;
            pll_odiv_o   <= 4'd1;
            pll_ctrl_o   <= 2'b00;
            pll_update_o <= 1'b0;
            pll_bypass_o <= 1'b1;
            status_o     <= ST_OK;
            err_o        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cfg_q        <= cfg_d;
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            lock_meta_q  <= pll_lock_i;
            lock_sync_q  <= lock_meta_q;
            cfg_ready_o  <= ready_d;
            pll_mult_o   <= mult_d;
            pll_rdiv_o   <= rdiv_d;
            pll_odiv_o   <= odiv_d;
            pll_ctrl_o   <= ctrl_d;
            pll_update_o <= update_d;
            pll_bypass_o <= bypass_d;
            status_o     <= status_d;
            err_o        <= err_d;
        end
    end

    // Next state and next output values
    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        ready_d  = cfg_ready_o;
        mult_d   = pll_mult_o;
        rdiv_d   = pll_rdiv_o;
        odiv_d   = pll_odiv_o;
        ctrl_d   = pll_ctrl_o;
        update_d = 1'b0;
        bypass_d = pll_bypass_o;
        status_d = status_o;
        err_d    = err_o;

        unique case (state_q)
            S_IDLE: begin
                if (cfg_valid_i && cfg_ready_o) begin
                    cfg_d    = cfg_in;
                    err_d    = 1'b0;
                    ready_d  = 1'b0;
                    status_d = ST_BUSY;
                    cnt_d    = '0;
                    if (cfg_bad) begin
                        state_d = S_REJECT;
                    end else begin
                        state_d  = S_BYPASS;
                        bypass_d = 1'b1;
                    end
                end
            end
            S_REJECT: begin
                state_d  = S_IDLE;
                status_d = ST_BAD;
                err_d    = 1'b1;
                ready_d  = 1'b1;
            end
            S_BYPASS: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d  = S_PROGRAM;
                    mult_d   = cfg_q.mult;
                    rdiv_d   = cfg_q.rdiv;
                    odiv_d   = cfg_q.odiv;
                    ctrl_d   = {cfg_q.fb_en, cfg_q.bw};
                    update_d = 1'b1;
                    cnt_d    = '0;
                    stable_d = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            S_PROGRAM: begin
                state_d = S_LOCK_WAIT;
            end
            S_LOCK_WAIT: begin
                stable_d = lock_sync_q ? sat_inc(stable_q) : '0;
                cnt_d    = sat_inc(cnt_q);
                // A lock that completes on the timeout cycle still counts as a lock
                if (lock_sync_q && (stable_q == STABLE_LAST)) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = S_FAIL;
                end
            end
            S_RELEASE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d  = S_IDLE;
                    bypass_d = 1'b0;
                    status_d = ST_OK;
                    ready_d  = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            S_FAIL: begin
                state_d  = S_IDLE;
                status_d = ST_TIMEOUT;
                err_d    = 1'b1;
                ready_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_soc_pll_cfg_ctrl.sv
// Directed bench for soc_pll_cfg_ctrl: table of config words plus hand-timed sequences
// for reject, lock timeout, lock glitch, held second word and mid-operation reset.
module tb_soc_pll_cfg_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cfg_i;
    logic        cfg_valid_i;
    logic        cfg_ready_o;
    logic [7:0]  pll_mult_o;
    logic [3:0]  pll_rdiv_o;
    logic [3:0]  pll_odiv_o;
    logic [1:0]  pll_ctrl_o;
    logic        pll_update_o;
    logic        pll_bypass_o;
    logic        pll_lock_i;
    logic [1:0]  status_o;
    logic        err_o;

    int errors = 0;
    int checks = 0;
    int upd_cnt = 0;

    soc_pll_cfg_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_i        (cfg_i),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .pll_mult_o   (pll_mult_o),
        .pll_rdiv_o   (pll_rdiv_o),
        .pll_odiv_o   (pll_odiv_o),
        .pll_ctrl_o   (pll_ctrl_o),
        .pll_update_o (pll_update_o),
        .pll_bypass_o (pll_bypass_o),
        .pll_lock_i   (pll_lock_i),
        .status_o     (status_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pll_update_o) upd_cnt = upd_cnt + 1;
    end

    typedef struct {
        logic [31:0] cfg;
        logic [1:0]  st;
        logic        err;
        logic [7:0]  mult;
        logic [3:0]  rdiv;
        logic [3:0]  odiv;
        logic [1:0]  ctrl;
        int          upd;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name, input int budget);
        int k;
        k = 0;
        while (!cfg_ready_o && k < budget) begin
            tick(1);
            k++;
        end
        chk({name, "_ready_timeout"}, 32'(cfg_ready_o), 32'd1);
    endtask

    task automatic chk_pins(input string name, input logic [7:0] m, input logic [3:0] r,
                            input logic [3:0] o, input logic [1:0] c);
        chk({name, "_mult"}, 32'(pll_mult_o), 32'(m));
        chk({name, "_rdiv"}, 32'(pll_rdiv_o), 32'(r));
        chk({name, "_odiv"}, 32'(pll_odiv_o), 32'(o));
        chk({name, "_ctrl"}, 32'(pll_ctrl_o), 32'(c));
    endtask

    task automatic accept(input logic [31:0] w);
        cfg_i       = w;
        cfg_valid_i = 1'b1;
        tick(1);
        cfg_valid_i = 1'b0;
    endtask

    initial begin
        int ups0;
        //            cfg            st     err  mult   rdiv  odiv  ctrl   upd
        vecs[0] = '{32'hFFFC_1120, 2'b00, 1'b0, 8'h20, 4'h1, 4'h1, 2'b00, 1};
        vecs[1] = '{32'h0001_3205, 2'b00, 1'b0, 8'h05, 4'h2, 4'h3, 2'b01, 1};
        vecs[2] = '{32'h0002_0A40, 2'b01, 1'b1, 8'h05, 4'h2, 4'h3, 2'b01, 0};
        vecs[3] = '{32'h0003_F0FF, 2'b01, 1'b1, 8'h05, 4'h2, 4'h3, 2'b01, 0};
        vecs[4] = '{32'h0000_FFFF, 2'b00, 1'b0, 8'hFF, 4'hF, 4'hF, 2'b00, 1};
        vecs[5] = '{32'h0002_1100, 2'b01, 1'b1, 8'hFF, 4'hF, 4'hF, 2'b00, 0};
        vecs[6] = '{32'h0002_8701, 2'b00, 1'b0, 8'h01, 4'h7, 4'h8, 2'b10, 1};

        rst_n = 1'b0; cfg_i = '0; cfg_valid_i = 1'b0; pll_lock_i = 1'b0;
        tick(2);
        chk("rst_ready", 32'(cfg_ready_o), 32'd1);
        chk("rst_bypass", 32'(pll_bypass_o), 32'd1);
        chk("rst_update", 32'(pll_update_o), 32'd0);
        chk("rst_status", 32'(status_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk_pins("rst", 8'd1, 4'd1, 4'd1, 2'd0);
        rst_n = 1'b1;
        tick(2);

        // Reject straight from reset: one busy cycle, then status 01
        accept(32'h0000_1100);
        chk("rej_ready_busy", 32'(cfg_ready_o), 32'd0);
        chk("rej_status_busy", 32'(status_o), 32'd3);
        tick(1);
        chk("rej_ready_back", 32'(cfg_ready_o), 32'd1);
        chk("rej_status", 32'(status_o), 32'd1);
        chk("rej_err", 32'(err_o), 32'd1);
        chk("rej_bypass", 32'(pll_bypass_o), 32'd1);
        chk("rej_updates", 32'(upd_cnt), 32'd0);
        chk_pins("rej", 8'd1, 4'd1, 4'd1, 2'd0);

        // Nominal word; update at accept+16, lock raw high 3 cycles after PROGRAM,
        // sync visible at P+5, 32 stable cycles -> RELEASE at P+37, IDLE at P+53
        ups0 = upd_cnt;
        accept(32'h0000_1120);
        chk("t1_err_clear", 32'(err_o), 32'd0);
        chk("t1_status_busy", 32'(status_o), 32'd3);
        tick(15);
        chk("t1_no_update_yet", 32'(pll_update_o), 32'd0);
        tick(1);
        chk("t1_update", 32'(pll_update_o), 32'd1);
        chk("t1_mult", 32'(pll_mult_o), 32'h20);
        chk("t1_bypass_prog", 32'(pll_bypass_o), 32'd1);
        tick(3);
        pll_lock_i = 1'b1;
        tick(49);
        chk("t1_bypass_before", 32'(pll_bypass_o), 32'd1);
        chk("t1_ready_before", 32'(cfg_ready_o), 32'd0);
        tick(1);
        chk("t1_bypass_drop", 32'(pll_bypass_o), 32'd0);
        chk("t1_ready", 32'(cfg_ready_o), 32'd1);
        chk("t1_status", 32'(status_o), 32'd0);
        chk("t1_updates", 32'(upd_cnt - ups0), 32'd1);

        // Table of words with lock held high
        for (int i = 0; i < 7; i++) begin
            ups0 = upd_cnt;
            accept(vecs[i].cfg);
            wait_ready($sformatf("vec%0d", i), 200);
            chk($sformatf("vec%0d_status", i), 32'(status_o), 32'(vecs[i].st));
            chk($sformatf("vec%0d_err", i), 32'(err_o), 32'(vecs[i].err));
            chk($sformatf("vec%0d_bypass", i), 32'(pll_bypass_o), 32'd0);
            chk($sformatf("vec%0d_updates", i), 32'(upd_cnt - ups0), 32'(vecs[i].upd));
            chk_pins($sformatf("vec%0d", i), vecs[i].mult, vecs[i].rdiv, vecs[i].odiv,
                     vecs[i].ctrl);
        end

        // Lock never rises: FAIL entered at P+4097, IDLE with status 10 at P+4098
        pll_lock_i = 1'b0;
        tick(3);
        accept(32'h0003_2410);
        tick(16);
        chk("t3_update", 32'(pll_update_o), 32'd1);
        tick(4096);
        chk("t3_ready_waiting", 32'(cfg_ready_o), 32'd0);
        tick(1);
        chk("t3_status_in_fail", 32'(status_o), 32'd3);
        tick(1);
        chk("t3_status", 32'(status_o), 32'd2);
        chk("t3_err", 32'(err_o), 32'd1);
        chk("t3_bypass", 32'(pll_bypass_o), 32'd1);
        chk("t3_ready", 32'(cfg_ready_o), 32'd1);
        chk_pins("t3", 8'h10, 4'h4, 4'h2, 2'b11);
        pll_lock_i = 1'b1;
        accept(32'h0000_1120);
        chk("t3_err_cleared", 32'(err_o), 32'd0);
        wait_ready("t3_recover", 200);
        chk("t3_recover_status", 32'(status_o), 32'd0);

        // Lock glitch: synced lock low in the cycle stable would read 20,
        // restart at P+22, RELEASE at P+54, IDLE at P+70
        accept(32'h0000_2240);
        tick(16);
        chk("t4_update", 32'(pll_update_o), 32'd1);
        tick(19);
        pll_lock_i = 1'b0;
        tick(1);
        pll_lock_i = 1'b1;
        tick(49);
        chk("t4_ready_before", 32'(cfg_ready_o), 32'd0);
        chk("t4_bypass_before", 32'(pll_bypass_o), 32'd1);
        tick(1);
        chk("t4_ready", 32'(cfg_ready_o), 32'd1);
        chk("t4_bypass", 32'(pll_bypass_o), 32'd0);
        chk("t4_mult", 32'(pll_mult_o), 32'h40);

        // Second word held valid while busy; first word done at accept+65
        ups0 = upd_cnt;
        cfg_i = 32'h0000_1130;
        cfg_valid_i = 1'b1;
        tick(1);
        cfg_i = 32'h0001_2318;
        tick(64);
        chk("t5_ready_busy", 32'(cfg_ready_o), 32'd0);
        chk("t5_status_busy", 32'(status_o), 32'd3);
        tick(1);
        chk("t5_ready_a", 32'(cfg_ready_o), 32'd1);
        chk("t5_mult_a", 32'(pll_mult_o), 32'h30);
        chk("t5_bypass_a", 32'(pll_bypass_o), 32'd0);
        tick(1);
        chk("t5_b_accepted", 32'(cfg_ready_o), 32'd0);
        chk("t5_b_status", 32'(status_o), 32'd3);
        cfg_valid_i = 1'b0;
        wait_ready("t5_b", 200);
        chk("t5_b_status_ok", 32'(status_o), 32'd0);
        chk_pins("t5_b", 8'h18, 4'h3, 4'h2, 2'b01);
        chk("t5_updates", 32'(upd_cnt - ups0), 32'd2);

        // Asynchronous reset in the middle of LOCK_WAIT
        pll_lock_i = 1'b0;
        tick(3);
        accept(32'h0000_1144);
        tick(16);
        chk("t6_update", 32'(pll_update_o), 32'd1);
        tick(10);
        ups0 = upd_cnt;
        #3 rst_n = 1'b0;
        #1;
        chk("t6_bypass", 32'(pll_bypass_o), 32'd1);
        chk("t6_ready", 32'(cfg_ready_o), 32'd1);
        chk("t6_status", 32'(status_o), 32'd0);
        chk("t6_err", 32'(err_o), 32'd0);
        chk("t6_update_low", 32'(pll_update_o), 32'd0);
        chk_pins("t6", 8'd1, 4'd1, 4'd1, 2'd0);
        tick(3);
        chk("t6_no_update", 32'(upd_cnt - ups0), 32'd0);
        rst_n = 1'b1;
        tick(2);
        chk("t6_ready_after", 32'(cfg_ready_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
